alu_arb: RTL
============

# alu_arb

Two-port arbiter and sequencer that shares the single 32-bit ALU between two requesters, e.g. the main datapath and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake and grants by round-robin or fixed priority. It drives registered operands and opcode into the ALU, captures the ALU result, and returns it to the granted requester over a second valid/ready handshake. It sits between the requesters and the ALU.

## Interface
- RR_EN, 1, 1 = round-robin grant; 0 = fixed priority, port 0 wins
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester n presents an operation
- req0_ready / req1_ready  out  1  operation on port n accepted this cycle
- req0_a / req1_a  in  32  operand a (signed)
- req0_b / req1_b  in  32  operand b (signed)
- req0_op / req1_op  in  4  ALU opcode, encoding from def.v (ADD, ADDU, SUBU, AND, OR, SLT, LUI)
- rsp0_valid / rsp1_valid  out  1  result available for port n
- rsp0_ready / rsp1_ready  in  1  port n consumes the result
- rsp_data  out  32  result; shared by both ports, meaningful only when the matching rsp valid is high
- alu_a, alu_b  out  32  registered operands to the ALU
- alu_op  out  4  registered opcode to the ALU
- alu_c  in  32  ALU result (combinational from alu_a/alu_b/alu_op)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, select a grant and assert req_ready combinationally for the granted port only.
  - On the edge, latch that port's a, b and op into alu_a, alu_b and alu_op, record the granted port, and go to EXEC.
  - If no request is valid, stay in IDLE. alu_* keep their last values.
- EXEC: ALU evaluates. On the edge, capture alu_c into rsp_data and go to RESP.
- RESP:
  - Assert rspN_valid for the granted port only.
  - Hold rsp_data and rspN_valid until rspN_ready is high.
  - On the accept edge, update the last-grant pointer to the granted port and go to IDLE.
- Grant, RR_EN=1:
  - Single valid port wins.
  - When both are valid, the port not granted last wins.
  - last resets to 1, so port 0 wins the first contention.
- Grant, RR_EN=0: port 0 always wins when both are valid.
- No new request is accepted in EXEC or RESP. req_ready is 0 in both states, and requesters hold valid and data.
- A requester that drops valid while not ready loses nothing; no request is latched.
- rspN_ready asserted when rspN_valid is low is ignored.
- Width rules: all 32-bit. Arithmetic and SLT semantics are those of the ALU. The arbiter never modifies data.
- Undefined opcodes pass through unchanged. The result is whatever the ALU produces, captured as-is.

## Timing
- Reset, synchronous: state=IDLE, last=1, alu_a=0, alu_b=0, alu_op=0, rsp_data=0.
- Outputs while rst is high or on the cycle after reset: req*_ready=0, rsp*_valid=0, busy=0.
- Reset in EXEC or RESP discards the in-flight operation. No response is issued.
- Latency:
  - Accept at cycle T (valid and ready both high).
  - EXEC in T+1.
  - rspN_valid high from T+2.
  - With rspN_ready already high, the response is consumed at T+2, IDLE in T+3, and the next accept is possible at T+3.
- Maximum throughput: one operation per 3 cycles.
- Backpressure: each extra cycle of rspN_ready=0 adds one cycle. rsp_data stays stable throughout.
- Simultaneous events:
  - Both ports valid in IDLE: exactly one ready is asserted.
  - The loser sees ready=0 and is granted next time IDLE is entered, provided it is still valid (RR_EN=1).
- busy rises the cycle after the accept edge and falls the cycle after the response is accepted.

## Test plan
- Port 0 only: ADDU a=5, b=7, rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2, rsp_data=0x0000000C, rsp1_valid stays 0.
- Port 1 only: SUBU a=3, b=5 -> rsp1_valid at T+2, rsp_data=0xFFFFFFFE. LUI b=0x00001234 -> 0x12340000.
- Contention, RR_EN=1: both ports hold valid continuously (port 0 SLT a=0xFFFFFFFF, b=1; port 1 OR a=0xF0, b=0x0F).
  - Grants alternate 0, 1, 0, 1.
  - Results are 0x00000001 and 0x000000FF on the correct rsp port.
- Contention, RR_EN=0: same stimulus -> port 0 granted every time. Port 1 is never granted while port 0 stays valid.
- Backpressure: hold rsp0_ready=0 for 4 cycles after rsp0_valid.
  - rsp_data is stable and rsp0_valid stays high.
  - Port 1 valid meanwhile sees req1_ready=0 and is accepted only after the response is consumed.
- Reset mid-operation: assert rst during EXEC.
  - No rsp valid follows, and all outputs take their reset values next cycle.
  - The first post-reset contention grants port 0.

Source files
------------

// File: rtl/alu_arb.sv
// alu_arb: shares one 32-bit ALU between two requesters using a round-robin or fixed-priority grant.
// Operands and opcode are registered toward the ALU, and the result is captured and returned to the granted port.
module alu_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [31:0] req0_a,
    input  logic signed [31:0] req0_b,
    input  logic        [3:0]  req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [31:0] req1_a,
    input  logic signed [31:0] req1_b,
    input  logic        [3:0]  req1_op,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic signed [31:0] rsp_data,
    output logic signed [31:0] alu_a,
    output logic signed [31:0] alu_b,
    output logic        [3:0]  alu_op,
    input  logic signed [31:0] alu_c,
    output logic               busy
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     gnt_q, gnt_d;
    logic signed [DATA_W-1:0] alu_a_q, alu_a_d;
    logic signed [DATA_W-1:0] alu_b_q, alu_b_d;
    logic        [3:0]        alu_op_q, alu_op_d;
    logic signed [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                     pick1;
    logic                     rsp_take;

    // On contention, round-robin favours the port that was not granted last.
    assign pick1    = req1_valid & (~req0_valid | (RR_EN & ~last_q));
    assign rsp_take = gnt_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    gnt_d    = pick1;
                    alu_a_d  = pick1 ? req1_a  : req0_a;
                    alu_b_d  = pick1 ? req1_b  : req0_b;
                    alu_op_d = pick1 ? req1_op : req0_op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_c;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_take) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Handshake outputs are forced low while reset is held, whatever the state register holds.
    assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~pick1;
    assign req1_ready = ~rst & (state_q == IDLE) & pick1;
    assign rsp0_valid = ~rst & (state_q == RESP) & ~gnt_q;
    assign rsp1_valid = ~rst & (state_q == RESP) & gnt_q;
    assign busy       = ~rst & (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;

endmodule
